// File: rtl/calu_accumulator.sv
// Central ALU and accumulator: load/add/sub/logic ops into a registered accumulator with carry/overflow flags.
// Optional CALU_ACCB_EN adds a secondary accumulator (accb) captured from acc on accb_save.
module calu_accumulator #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand,
   input  logic             ovm,
   input  logic             ov_clr,
`ifdef CALU_ACCB_EN
   input  logic             accb_save,
   output logic [WIDTH-1:0] accb,
`endif
   output logic [WIDTH-1:0] acc,
   output logic             carry,
   output logic             ov,
   output logic             zero,
   output logic             neg,
   output logic             out_valid
);

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LAC = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_ZAC = 3'b111;

   localparam logic signed [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   function automatic logic signed_ovf(input logic a_sign, input logic b_sign, input logic r_sign);
      return (a_sign == b_sign) && (r_sign != a_sign);
   endfunction

   function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] wrapped,
                                                        input logic ovf, input logic neg_dir,
                                                        input logic sat_en);
      if (ovf && sat_en)
         return neg_dir ? SAT_NEG : SAT_POS;
      return wrapped;
   endfunction

   logic                     is_sub_p0;
   logic        [WIDTH-1:0]  addend_p0;
   logic        [WIDTH:0]    sum_p0;
   logic                     ovf_p0;
   logic signed [WIDTH-1:0]  arith_p0;
   logic        [WIDTH-1:0]  next_acc_p0;
   logic                     next_carry_p0;
   logic                     set_ov_p0;

   // Subtraction reuses the adder as acc + ~operand + 1 so carry means "no borrow".
   always_comb begin
      is_sub_p0 = (op == OP_SUB);
      addend_p0 = is_sub_p0 ? ~operand : operand;
      sum_p0    = {1'b0, acc} + {1'b0, addend_p0} + {{WIDTH{1'b0}}, is_sub_p0};
      ovf_p0    = signed_ovf(acc[WIDTH-1], addend_p0[WIDTH-1], sum_p0[WIDTH-1]);
      arith_p0  = saturate(sum_p0[WIDTH-1:0], ovf_p0, acc[WIDTH-1], ovm);
   end

   always_comb begin
      next_acc_p0   = acc;
      next_carry_p0 = carry;
      set_ov_p0     = 1'b0;
      case (op)
         OP_NOP: ;
         OP_LAC: next_acc_p0 = operand;
         OP_ADD, OP_SUB: begin
            next_acc_p0   = arith_p0;
            next_carry_p0 = sum_p0[WIDTH];
            set_ov_p0     = ovf_p0;
         end
         OP_AND: next_acc_p0 = acc & operand;
         OP_OR:  next_acc_p0 = acc | operand;
         OP_XOR: next_acc_p0 = acc ^ operand;
         OP_ZAC: next_acc_p0 = '0;
         default: ;
      endcase
   end

   // Stage p0 -> registered accumulator and flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc       <= '0;
         carry     <= 1'b0;
         ov        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            acc   <= next_acc_p0;
            carry <= next_carry_p0;
         end
         // A fresh overflow outranks a simultaneous clear.
         if (in_valid && set_ov_p0)
            ov <= 1'b1;
         else if (ov_clr)
            ov <= 1'b0;
      end
   end

`ifdef CALU_ACCB_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         accb <= '0;
      else if (accb_save)
         accb <= acc;
   end
`endif

   assign zero = (acc == '0);
   assign neg  = acc[WIDTH-1];

endmodule
